// File: rtl/trace_pkg.sv
// Shared types for the retire trace path.
//   XLEN           : data width of instruction words and registers
//   NREGS          : architectural registers (RV32E)
//   REG_AW         : register address width
//   retire_entry_t : one captured retire {instr, rd_we, rd_addr, rd_data}
//   regfile_t      : packed register file, reg i at [XLEN*i +: XLEN]
package trace_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 16;
  localparam int REG_AW = $clog2(NREGS);

  typedef struct packed {
    logic [XLEN-1:0]   instr;
    logic              rd_we;
    logic [REG_AW-1:0] rd_addr;
    logic [XLEN-1:0]   rd_data;
  } retire_entry_t;

  typedef logic [NREGS-1:0][XLEN-1:0] regfile_t;

  // True when the entry changes architectural state (x0 is hardwired to zero).
  function automatic logic writes_reg(input retire_entry_t e);
    return e.rd_we && (e.rd_addr != '0);
  endfunction

endpackage

// File: rtl/trace_sync_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous flush, wins over push/pop
//   push/push_data : write an entry (caller guarantees !full or a same-cycle pop)
//   pop        : drop the head entry (caller guarantees !empty)
//   head       : entry at the read pointer, meaningful only when !empty
//   full, empty, count : occupancy status, count in 0..DEPTH
module trace_sync_fifo #(
  parameter int  DEPTH   = 8,
  parameter type entry_t = logic,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clear,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty,
  output logic [AW:0] count
);

  entry_t      mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // NOTE: storage is deliberately not reset; the pointers define validity and
  // the consumer masks the head while empty, so a reset RAM would be wasted logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/retire_trace_fifo.sv
// Retire trace buffer between the core's writeback point and the checker.
// Queues retired instructions, keeps a shadow RV32E register file, and shows
// one instruction at a time with the register state after it.
//   clk, rst_n      : clock, asynchronous active-low reset
//   clear_i         : synchronous clear of queue, shadow file, flags, counters
//   ret_*           : retire/writeback capture port
//   out_valid_o/out_ready_i : head handshake toward the checker
//   out_instr_o     : head instruction (0 when empty)
//   out_regs_o      : shadow file with the head writeback merged in
//   count_o         : occupancy
//   overflow_o      : sticky, a retire was dropped on a full queue
//   retired_cnt_o   : entries accepted, wraps modulo 2^32
module retire_trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_i,
  input  logic                    ret_valid_i,
  input  logic [XLEN-1:0]         ret_instr_i,
  input  logic                    ret_rd_we_i,
  input  logic [REG_AW-1:0]       ret_rd_addr_i,
  input  logic [XLEN-1:0]         ret_rd_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [XLEN-1:0]         out_instr_o,
  output logic [NREGS*XLEN-1:0]   out_regs_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    overflow_o,
  output logic [31:0]             retired_cnt_o
);

  retire_entry_t ret_entry;
  retire_entry_t head;
  regfile_t      shadow;
  regfile_t      merged;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign ret_entry = '{instr:   ret_instr_i,
                       rd_we:   ret_rd_we_i,
                       rd_addr: ret_rd_addr_i,
                       rd_data: ret_rd_data_i};

  assign pop  = !empty && out_ready_i;
  // A full queue still accepts a retire when the head leaves in the same cycle.
  assign push = ret_valid_i && (!full || pop);

  trace_sync_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (retire_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear_i),
    .push      (push),
    .push_data (ret_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count_o)
  );

  // The head's writeback becomes architectural exactly when the checker takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow        <= '0;
      overflow_o    <= 1'b0;
      retired_cnt_o <= '0;
    end else if (clear_i) begin
      shadow        <= '0;
      overflow_o    <= 1'b0;
      retired_cnt_o <= '0;
    end else begin
      if (pop && writes_reg(head)) shadow[head.rd_addr] <= head.rd_data;
      if (push) retired_cnt_o <= retired_cnt_o + 32'd1;
      if (ret_valid_i && !push) overflow_o <= 1'b1;
    end
  end

  // NOTE: combinational outputs get a full default first so no path can
  // leave them unassigned and infer a latch.
  always_comb begin
    merged = shadow;
    if (!empty && writes_reg(head)) merged[head.rd_addr] = head.rd_data;
  end

  assign out_valid_o = !empty;
  assign out_instr_o = empty ? '0 : head.instr;
  assign out_regs_o  = merged;

endmodule

// File: tb/tb_retire_trace_fifo.sv
module tb_retire_trace_fifo;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int NREGS = 16;
  localparam int RW    = NREGS * XLEN;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clear_i = 1'b0;
  logic            ret_valid_i = 1'b0;
  logic [31:0]     ret_instr_i = '0;
  logic            ret_rd_we_i = 1'b0;
  logic [3:0]      ret_rd_addr_i = '0;
  logic [31:0]     ret_rd_data_i = '0;
  logic            out_valid_o;
  logic            out_ready_i = 1'b0;
  logic [31:0]     out_instr_o;
  logic [RW-1:0]   out_regs_o;
  logic [3:0]      count_o;
  logic            overflow_o;
  logic [31:0]     retired_cnt_o;

  retire_trace_fifo #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_i       (clear_i),
    .ret_valid_i   (ret_valid_i),
    .ret_instr_i   (ret_instr_i),
    .ret_rd_we_i   (ret_rd_we_i),
    .ret_rd_addr_i (ret_rd_addr_i),
    .ret_rd_data_i (ret_rd_data_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_instr_o   (out_instr_o),
    .out_regs_o    (out_regs_o),
    .count_o       (count_o),
    .overflow_o    (overflow_o),
    .retired_cnt_o (retired_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   instr;
    logic [RW-1:0] regs;
  } exp_t;

  // Scoreboard: expected head values queued when a retire is accepted.
  exp_t          sb[$];
  logic [RW-1:0] m_tip;     // register state after the newest accepted retire
  logic [RW-1:0] m_shadow;  // register state after the last popped entry
  logic          m_ovf;
  logic [31:0]   m_cnt;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_tip    = '0;
    m_shadow = '0;
    m_ovf    = 1'b0;
    m_cnt    = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"},    RW'(out_valid_o),   RW'(sb.size() > 0));
    chk({tag, ".count"},    RW'(count_o),       RW'(sb.size()));
    chk({tag, ".overflow"}, RW'(overflow_o),    RW'(m_ovf));
    chk({tag, ".retired"},  RW'(retired_cnt_o), RW'(m_cnt));
    if (sb.size() > 0) begin
      chk({tag, ".instr"}, RW'(out_instr_o), RW'(sb[0].instr));
      chk({tag, ".regs"},  out_regs_o,       sb[0].regs);
    end else begin
      chk({tag, ".instr"}, RW'(out_instr_o), '0);
      chk({tag, ".regs"},  out_regs_o,       m_shadow);
    end
  endtask

  // One clock: check current outputs, drive this cycle's inputs, update model.
  task automatic cycle(input string tag, input logic rv, input logic [31:0] ins,
                       input logic we, input logic [3:0] ad, input logic [31:0] dat,
                       input logic rdy, input logic clr);
    bit   will_pop;
    bit   will_push;
    exp_t e;
    @(negedge clk);
    check_outputs(tag);
    ret_valid_i   = rv;
    ret_instr_i   = ins;
    ret_rd_we_i   = we;
    ret_rd_addr_i = ad;
    ret_rd_data_i = dat;
    out_ready_i   = rdy;
    clear_i       = clr;
    will_pop  = (sb.size() > 0) && rdy;
    will_push = rv && ((sb.size() < DEPTH) || will_pop);
    @(posedge clk);
    if (clr) begin
      model_reset();
    end else begin
      if (will_pop) begin
        e = sb.pop_front();
        m_shadow = e.regs;
      end
      if (will_push) begin
        if (we && ad != 4'd0) m_tip[int'(ad)*XLEN +: XLEN] = dat;
        e.instr = ins;
        e.regs  = m_tip;
        sb.push_back(e);
        m_cnt = m_cnt + 32'd1;
      end else if (rv) begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic idle(input string tag, input logic rdy);
    cycle(tag, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, rdy, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    ret_valid_i = 1'b0;
    out_ready_i = 1'b0;
    clear_i     = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs({tag, ".async"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    do_reset("por");

    // Single retire: addi x5, x0, 10
    cycle("addi", 1'b1, 32'h00A00293, 1'b1, 4'd5, 32'd10, 1'b1, 1'b0);
    idle("addi_head", 1'b1);
    idle("addi_after", 1'b1);

    // Write to x0 must never become visible
    cycle("x0", 1'b1, 32'h00000013, 1'b1, 4'd0, 32'hDEADBEEF, 1'b1, 1'b0);
    idle("x0_head", 1'b1);
    idle("x0_after", 1'b1);

    // Back-pressure: fill with x1..x8 = 1..8 from a clean state
    do_reset("bp_rst");
    for (int i = 1; i <= DEPTH; i++)
      cycle($sformatf("bp_fill%0d", i), 1'b1, 32'h00000093 + (i << 7), 1'b1,
            4'(i), 32'(i), 1'b0, 1'b0);
    idle("bp_full", 1'b0);

    // Overflow: ninth retire while full and stalled is dropped
    cycle("ovf_drop", 1'b1, 32'hBADBAD13, 1'b1, 4'd9, 32'h99, 1'b0, 1'b0);
    idle("ovf_sticky", 1'b0);

    // Full with simultaneous push and pop: new x9 entry goes to the tail
    cycle("full_pp", 1'b1, 32'h00900493, 1'b1, 4'd9, 32'd9, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++)
      idle($sformatf("drain%0d", i), 1'b1);

    // Reset mid-stream with three entries queued
    for (int i = 1; i <= 3; i++)
      cycle($sformatf("rst_q%0d", i), 1'b1, 32'h00000113 + i, 1'b1,
            4'(i + 10), 32'(i * 100), 1'b0, 1'b0);
    idle("rst_queued", 1'b0);
    do_reset("mid_rst");
    idle("mid_rst_after", 1'b1);

    // Clear mid-stream with three entries queued; clear beats a retire
    for (int i = 1; i <= 3; i++)
      cycle($sformatf("clr_q%0d", i), 1'b1, 32'h00000213 + i, 1'b1,
            4'(i + 1), 32'(i * 7), 1'b0, 1'b0);
    cycle("clr", 1'b1, 32'h12345678, 1'b1, 4'd6, 32'd66, 1'b1, 1'b1);
    idle("clr_after", 1'b1);
    idle("clr_after2", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
